uart_rx_block_assembler: RTL and testbench

Collects the byte stream from `uart_rx` into 128-bit AES blocks and presents each complete block as a single AXI4-Stream beat to the AES core. It sits directly downstream of `uart_rx`: it consumes its 8-bit `m_axis_rx` stream and its error flags. It discards partial blocks on line errors or on an inter-byte timeout measured in `baud_clk` ticks, so the AES core only ever sees whole, clean blocks.

---
 rtl/uart_rx_block_assembler_if.sv | 18 +
 rtl/uart_rx_block_assembler.sv | 129 ++++++++++++
 tb/tb_uart_rx_block_assembler.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_block_assembler_if.sv
// rtl/uart_rx_block_assembler_if.sv - AXI4-Stream style bundle shared by the byte and block streams
interface taxi_axis_if #(
  parameter int DATA_W = 8
);
  localparam int KEEP_W = (DATA_W + 7) / 8;

  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic              tuser;

  modport src    (output tdata, tkeep, tvalid, tlast, tuser, input tready);
  modport snk    (input tdata, tkeep, tvalid, tlast, tuser, output tready);
  modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/uart_rx_block_assembler.sv
// rtl/uart_rx_block_assembler.sv - packs uart_rx bytes into whole AES blocks, dropping partial blocks on error or timeout
module uart_rx_block_assembler #(
  parameter int BLK_BYTES = 16,
  parameter int TIMEOUT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  taxi_axis_if.snk                   s_axis_rx,
  taxi_axis_if.src                   m_axis_blk,
  input  logic                       baud_clk,
  input  logic                       frame_error,
  input  logic                       parity_error,
  input  logic                       overrun_error,
  input  logic [TIMEOUT_W-1:0]       timeout_ticks,
  output logic                       busy,
  output logic [$clog2(BLK_BYTES):0] byte_cnt,
  output logic                       timeout_event,
  output logic                       err_drop,
  output logic [7:0]                 drop_count
);
  localparam int CNT_W = $clog2(BLK_BYTES) + 1;
  localparam int BLK_W = 8 * BLK_BYTES;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLK_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t               state;
  logic [BLK_W-1:0]     blk_data;
  logic                 blk_valid;
  logic [TIMEOUT_W-1:0] tick_cnt;

  logic                 err_any;
  logic                 accept;
  logic                 tick_hit;
  logic [TIMEOUT_W-1:0] tick_inc;
  logic [CNT_W-1:0]     cnt_inc;
  logic [7:0]           drop_sat;
  logic                 unused_sideband;

  assign err_any  = frame_error | parity_error | overrun_error;
  assign accept   = s_axis_rx.tvalid && s_axis_rx.tready;
  assign tick_inc = tick_cnt + TIMEOUT_W'(1);
  assign cnt_inc  = byte_cnt + CNT_W'(1);
  assign drop_sat = (drop_count == 8'hFF) ? drop_count : drop_count + 8'd1;
  // Timeout only counts while a partial block is held and is disabled by a zero limit.
  assign tick_hit = (state == FILL) && baud_clk && (timeout_ticks != '0) && (tick_inc == timeout_ticks);

  assign s_axis_rx.tready = (state != OUT);
  assign m_axis_blk.tdata  = blk_data;
  assign m_axis_blk.tvalid = blk_valid;
  assign m_axis_blk.tlast  = 1'b1;
  assign m_axis_blk.tkeep  = '0;
  assign m_axis_blk.tuser  = 1'b0;

  // Byte-level sideband carries nothing useful for block assembly.
  assign unused_sideband = ^{s_axis_rx.tkeep, s_axis_rx.tlast, s_axis_rx.tuser};

  // Block assembly FSM: error beats byte, byte beats timeout, OUT ignores errors.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      blk_data      <= '0;
      blk_valid     <= 1'b0;
      tick_cnt      <= '0;
      byte_cnt      <= '0;
      busy          <= 1'b0;
      timeout_event <= 1'b0;
      err_drop      <= 1'b0;
      drop_count    <= 8'd0;
    end else begin
      timeout_event <= 1'b0;
      err_drop      <= 1'b0;
      case (state)
        IDLE, FILL: begin
          if (err_any) begin
            // In IDLE nothing is held, so only a FILL error counts as a drop.
            if (state == FILL) begin
              err_drop   <= 1'b1;
              drop_count <= drop_sat;
            end
            state    <= IDLE;
            byte_cnt <= '0;
            tick_cnt <= '0;
            busy     <= 1'b0;
          end else if (accept) begin
            blk_data <= {blk_data[BLK_W-9:0], s_axis_rx.tdata};
            byte_cnt <= cnt_inc;
            tick_cnt <= '0;
            busy     <= 1'b1;
            if (byte_cnt == LAST_CNT) begin
              state     <= OUT;
              blk_valid <= 1'b1;
            end else begin
              state <= FILL;
            end
          end else if (tick_hit) begin
            timeout_event <= 1'b1;
            drop_count    <= drop_sat;
            state         <= IDLE;
            byte_cnt      <= '0;
            tick_cnt      <= '0;
            busy          <= 1'b0;
          end else if (state == FILL && baud_clk) begin
            tick_cnt <= tick_inc;
          end
        end
        OUT: begin
          if (m_axis_blk.tready) begin
            state     <= IDLE;
            blk_valid <= 1'b0;
            byte_cnt  <= '0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          blk_valid <= 1'b0;
          byte_cnt  <= '0;
          tick_cnt  <= '0;
          busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_block_assembler.sv
// tb/tb_uart_rx_block_assembler.sv - directed table-driven bench for uart_rx_block_assembler
module tb_uart_rx_block_assembler;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        baud_clk = 1'b0;
  logic        frame_error = 1'b0;
  logic        parity_error = 1'b0;
  logic        overrun_error = 1'b0;
  logic [15:0] timeout_ticks = 16'd0;
  logic        busy;
  logic [4:0]  byte_cnt;
  logic        timeout_event;
  logic        err_drop;
  logic [7:0]  drop_count;

  int total = 0;
  int bad = 0;
  int beats = 0;
  int exp_drops = 0;

  localparam logic [127:0] BLK_00 = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] BLK_10 = 128'h101112131415161718191A1B1C1D1E1F;
  localparam logic [127:0] BLK_A0 = 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF;
  localparam logic [127:0] BLK_F0 = 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF;

  typedef struct {
    logic [7:0]   base;
    int           stall;
    logic [127:0] exp;
  } vec_t;

  vec_t vt [4];

  taxi_axis_if #(.DATA_W(8))   s_if ();
  taxi_axis_if #(.DATA_W(128)) m_if ();

  uart_rx_block_assembler #(.BLK_BYTES(16), .TIMEOUT_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_rx     (s_if),
    .m_axis_blk    (m_if),
    .baud_clk      (baud_clk),
    .frame_error   (frame_error),
    .parity_error  (parity_error),
    .overrun_error (overrun_error),
    .timeout_ticks (timeout_ticks),
    .busy          (busy),
    .byte_cnt      (byte_cnt),
    .timeout_event (timeout_event),
    .err_drop      (err_drop),
    .drop_count    (drop_count)
  );

  always #5 clk = ~clk;

  // Count every completed output beat.
  always @(posedge clk) begin
    if (rst && m_if.tvalid && m_if.tready) beats <= beats + 1;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    s_if.tvalid = 1'b1;
    s_if.tdata  = b;
    cyc();
    s_if.tvalid = 1'b0;
  endtask

  task automatic tick();
    baud_clk = 1'b1;
    cyc();
    baud_clk = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_s_tready"}, s_if.tready, 1);
    chk({tag, "_m_tvalid"}, m_if.tvalid, 0);
    chk({tag, "_m_tdata"}, m_if.tdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_byte_cnt"}, byte_cnt, 0);
    chk({tag, "_timeout_event"}, timeout_event, 0);
    chk({tag, "_err_drop"}, err_drop, 0);
    chk({tag, "_drop_count"}, drop_count, 0);
  endtask

  task automatic run_block(input logic [7:0] base, input int stall, input logic [127:0] exp, input string tag);
    int b0;
    b0 = beats;
    m_if.tready = (stall == 0);
    for (int i = 0; i < 16; i++) send(8'(base + 8'(i)));
    chk({tag, "_tvalid"}, m_if.tvalid, 1);
    chk({tag, "_tdata"}, m_if.tdata, exp);
    chk({tag, "_tlast"}, m_if.tlast, 1);
    chk({tag, "_s_tready_out"}, s_if.tready, 0);
    chk({tag, "_byte_cnt_full"}, byte_cnt, 16);
    for (int s = 0; s < stall; s++) begin
      cyc();
      chk({tag, "_stall_tdata"}, m_if.tdata, exp);
      chk({tag, "_stall_s_tready"}, s_if.tready, 0);
    end
    m_if.tready = 1'b1;
    cyc();
    chk({tag, "_tvalid_done"}, m_if.tvalid, 0);
    chk({tag, "_s_tready_back"}, s_if.tready, 1);
    chk({tag, "_busy_done"}, busy, 0);
    chk({tag, "_beats"}, beats, b0 + 1);
    chk({tag, "_drop_count"}, drop_count, exp_drops);
  endtask

  initial begin
    int b0;
    int early;
    s_if.tvalid = 1'b0;
    s_if.tdata  = 8'd0;
    s_if.tlast  = 1'b0;
    s_if.tkeep  = 1'b0;
    s_if.tuser  = 1'b0;
    m_if.tready = 1'b1;

    vt[0] = '{base: 8'h00, stall: 0,  exp: BLK_00};
    vt[1] = '{base: 8'h10, stall: 20, exp: BLK_10};
    vt[2] = '{base: 8'hA0, stall: 0,  exp: BLK_A0};
    vt[3] = '{base: 8'hF0, stall: 3,  exp: BLK_F0};

    #12;
    chk_reset("reset");
    rst = 1'b1;
    cyc();

    for (int v = 0; v < 4; v++) run_block(vt[v].base, vt[v].stall, vt[v].exp, $sformatf("vec%0d", v));

    // Error drop after 7 bytes, once per error source.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 7; i++) send(8'(8'h30 + 8'(i)));
      chk("err_pre_cnt", byte_cnt, 7);
      parity_error  = (k == 0);
      frame_error   = (k == 1);
      overrun_error = (k == 2);
      cyc();
      parity_error = 1'b0; frame_error = 1'b0; overrun_error = 1'b0;
      exp_drops++;
      chk("err_drop_pulse", err_drop, 1);
      chk("err_byte_cnt", byte_cnt, 0);
      chk("err_busy", busy, 0);
      chk("err_drop_count", drop_count, exp_drops);
      cyc();
      chk("err_drop_clear", err_drop, 0);
      run_block(8'h10, 0, BLK_10, "after_err");
    end

    // Error while idle and empty: nothing dropped.
    parity_error = 1'b1;
    cyc();
    parity_error = 1'b0;
    chk("idle_err_no_pulse", err_drop, 0);
    chk("idle_err_count", drop_count, exp_drops);

    // Error with the 16th byte: no block.
    b0 = beats;
    m_if.tready = 1'b1;
    for (int i = 0; i < 15; i++) send(8'(i));
    frame_error = 1'b1;
    send(8'h0F);
    frame_error = 1'b0;
    exp_drops++;
    chk("err16_pulse", err_drop, 1);
    chk("err16_tvalid", m_if.tvalid, 0);
    chk("err16_byte_cnt", byte_cnt, 0);
    chk("err16_count", drop_count, exp_drops);
    cyc();
    chk("err16_no_beat", beats, b0);

    // Error while presenting a block is ignored.
    b0 = beats;
    m_if.tready = 1'b0;
    for (int i = 0; i < 16; i++) send(8'(i));
    overrun_error = 1'b1;
    cyc();
    overrun_error = 1'b0;
    chk("out_err_tvalid", m_if.tvalid, 1);
    chk("out_err_tdata", m_if.tdata, BLK_00);
    chk("out_err_no_pulse", err_drop, 0);
    m_if.tready = 1'b1;
    cyc();
    chk("out_err_beat", beats, b0 + 1);
    chk("out_err_count", drop_count, exp_drops);

    // Timeout of 160 ticks at one tick per 8 cycles.
    b0 = beats;
    timeout_ticks = 16'd160;
    for (int i = 0; i < 5; i++) send(8'(8'h50 + 8'(i)));
    early = 0;
    for (int t = 1; t <= 160; t++) begin
      tick();
      if (t < 160) begin
        if (timeout_event) early++;
        repeat (7) cyc();
      end else begin
        exp_drops++;
        chk("to_event", timeout_event, 1);
        chk("to_byte_cnt", byte_cnt, 0);
        chk("to_busy", busy, 0);
        chk("to_count", drop_count, exp_drops);
      end
    end
    chk("to_no_early", early, 0);
    cyc();
    chk("to_event_clear", timeout_event, 0);
    chk("to_no_beat", beats, b0);
    run_block(8'hA0, 0, BLK_A0, "after_to");

    // Byte and tick together: byte wins and restarts the count.
    timeout_ticks = 16'd4;
    send(8'h01);
    repeat (3) tick();
    s_if.tvalid = 1'b1; s_if.tdata = 8'h02; baud_clk = 1'b1;
    cyc();
    s_if.tvalid = 1'b0; baud_clk = 1'b0;
    chk("sim_byte_no_to", timeout_event, 0);
    chk("sim_byte_cnt", byte_cnt, 2);
    repeat (3) tick();
    chk("sim_restart_no_to", timeout_event, 0);
    tick();
    exp_drops++;
    chk("sim_restart_to", timeout_event, 1);
    chk("sim_restart_cnt", byte_cnt, 0);
    chk("sim_restart_count", drop_count, exp_drops);

    // Error and timeout together: counted once as an error.
    send(8'h03);
    repeat (3) tick();
    baud_clk = 1'b1; parity_error = 1'b1;
    cyc();
    baud_clk = 1'b0; parity_error = 1'b0;
    exp_drops++;
    chk("errto_err", err_drop, 1);
    chk("errto_no_to", timeout_event, 0);
    chk("errto_count", drop_count, exp_drops);

    // Zero timeout keeps a partial block forever.
    timeout_ticks = 16'd0;
    for (int i = 0; i < 3; i++) send(8'(i));
    early = 0;
    baud_clk = 1'b1;
    for (int t = 0; t < 300; t++) begin
      cyc();
      if (timeout_event) early++;
    end
    baud_clk = 1'b0;
    chk("to0_no_event", early, 0);
    chk("to0_byte_cnt", byte_cnt, 3);

    // Reset mid-fill after 9 bytes.
    for (int i = 3; i < 9; i++) send(8'(i));
    chk("rst_pre_cnt", byte_cnt, 9);
    rst = 1'b0;
    #2;
    chk_reset("midreset");
    exp_drops = 0;
    @(negedge clk);
    rst = 1'b1;
    cyc();
    run_block(8'h00, 0, BLK_00, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
